// File: rtl/jt6805_mouse_pkg.sv
// Shared definitions for the 6805 mouse quadrature generator.
//   phase_t          : quadrature phase {a1,a2}, named after its bit pattern
//   DELTAW           : width of a per-axis delta after inversion/acceleration
//   IRQ_CW           : width of the irq stretch counter
//   phase_next/prev  : one quadrature step forward (a1 leads) / backward
//   sat_add          : add and clamp to +/-(2^(accw-1)-1)
package jt6805_mouse_pkg;

   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_10 = 2'b10,
      PH_11 = 2'b11,
      PH_01 = 2'b01
   } phase_t;

   // 9-bit delta doubled by acceleration spans -512..+512
   localparam int DELTAW = 11;
   localparam int IRQ_CW = 4;

   function automatic phase_t phase_next(input phase_t p);
      phase_t n;
      n = PH_00;
      case (p)
         PH_00:   n = PH_10;
         PH_10:   n = PH_11;
         PH_11:   n = PH_01;
         PH_01:   n = PH_00;
         default: n = PH_00;
      endcase
      return n;
   endfunction

   function automatic phase_t phase_prev(input phase_t p);
      phase_t n;
      n = PH_00;
      case (p)
         PH_00:   n = PH_01;
         PH_01:   n = PH_11;
         PH_11:   n = PH_10;
         PH_10:   n = PH_00;
         default: n = PH_00;
      endcase
      return n;
   endfunction

   // Symmetric clamp: the most negative code is never produced, so the
   // backward step count always equals the magnitude of the accumulator.
   function automatic int sat_add(input int acc, input int delta, input int accw);
      int lim;
      int sum;
      lim = (1 << (accw - 1)) - 1;
      sum = acc + delta;
      if (sum > lim) return lim;
      if (sum < -lim) return -lim;
      return sum;
   endfunction

endpackage

// File: rtl/jt6805_quad_axis.sv
// One mouse axis: signed saturating motion accumulator plus quadrature phase.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   i_step_tick  : one-clk step opportunity from the shared step timer
//   i_strobe     : new delta valid this clk
//   i_delta      : signed delta, already inverted/accelerated by the top
//   o_a1, o_a2   : quadrature pair, straight from the phase register
module jt6805_quad_axis
   import jt6805_mouse_pkg::*;
#(
   parameter int ACCW = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_step_tick,
   input  logic                     i_strobe,
   input  logic signed [DELTAW-1:0] i_delta,
   output logic                     o_a1,
   output logic                     o_a2
);

   logic signed [ACCW-1:0] r_acc;
   phase_t                 r_phase;
   logic                   w_zero;
   logic                   w_fwd;
   logic                   w_bwd;
   int                     w_adj;
   int                     w_sat;

   assign w_zero = (r_acc == '0);
   assign w_fwd  = i_step_tick && !w_zero && !r_acc[ACCW-1];
   assign w_bwd  = i_step_tick && r_acc[ACCW-1];

   // A strobe and a step on the same clk fold into one update; the step
   // direction comes from the accumulator before this update.
   always_comb begin
      w_adj = i_strobe ? int'(i_delta) : 0;
      if (w_fwd)
         w_adj = w_adj - 1;
      else if (w_bwd)
         w_adj = w_adj + 1;
      w_sat = sat_add(int'(r_acc), w_adj, ACCW);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= '0;
         r_phase <= PH_00;
      end else begin
         r_acc <= ACCW'(w_sat);
         if (w_fwd)
            r_phase <= phase_next(r_phase);
         else if (w_bwd)
            r_phase <= phase_prev(r_phase);
      end
   end

   assign {o_a1, o_a2} = r_phase;

endmodule

// File: rtl/jt6805_quadgen.sv
// Mouse motion to quadrature converter feeding the 6805 mouse MCU.
// Relative-motion packets are accumulated per axis and replayed as
// quadrature steps at a fixed rate, with a button level and an irq pulse.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   cen             : clock enable shared with the MCU (step timer, irq length)
//   strobe          : one-clk pulse, dx/dy/btn valid (honoured regardless of cen)
//   dx, dy          : signed 9-bit motion deltas
//   btn             : left button, 1 = pressed
//   x1, x2, y1, y2  : quadrature pairs
//   btn_n           : registered button, active low
//   irq             : IRQW-cen-tick pulse on every x1 or y1 rising edge
// Build option: define MOUSE_ACCEL_EN to double deltas with |d| >= ACC_THR.
module jt6805_quadgen
   import jt6805_mouse_pkg::*;
#(
   parameter int ACCW     = 10,
   parameter int STEPW    = 12,
   parameter int STEP_PER = 400,
   parameter int IRQW     = 4,
   parameter int YINV     = 1,
   parameter int ACC_THR  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cen,
   input  logic              strobe,
   input  logic signed [8:0] dx,
   input  logic signed [8:0] dy,
   input  logic              btn,
   output logic              x1,
   output logic              x2,
   output logic              y1,
   output logic              y2,
   output logic              btn_n,
   output logic              irq
);

`ifdef MOUSE_ACCEL_EN
   localparam bit ACCEL_EN = 1'b1;
`else
   localparam bit ACCEL_EN = 1'b0;
`endif

   localparam logic [STEPW-1:0]  STEP_LAST = STEPW'(STEP_PER - 1);
   localparam logic [IRQ_CW-1:0] IRQ_LOAD  = IRQ_CW'(IRQW);

   logic [STEPW-1:0]         r_step_cnt;
   logic                     w_step_tick;
   logic [IRQ_CW-1:0]        r_irq_cnt;
   logic                     r_x1_d;
   logic                     r_y1_d;
   logic                     r_btn_n;
   logic                     w_rise;
   logic signed [DELTAW-1:0] w_dx_e;
   logic signed [DELTAW-1:0] w_dy_e;
   logic signed [DELTAW-1:0] w_dx_s;
   logic signed [DELTAW-1:0] w_dy_s;

   function automatic logic signed [DELTAW-1:0] accel(input logic signed [DELTAW-1:0] d);
      logic signed [DELTAW-1:0] mag;
      mag = d[DELTAW-1] ? -d : d;
      if (ACCEL_EN && (int'(mag) >= ACC_THR))
         return d <<< 1;
      return d;
   endfunction

   // Widen before negating so dy = -256 inverts to +256 without overflow.
   assign w_dx_e = DELTAW'(dx);
   assign w_dy_e = (YINV != 0) ? -DELTAW'(dy) : DELTAW'(dy);
   assign w_dx_s = accel(w_dx_e);
   assign w_dy_s = accel(w_dy_e);

   assign w_step_tick = cen && (r_step_cnt == STEP_LAST);

   always_ff @(posedge clk) begin
      if (rst)
         r_step_cnt <= '0;
      else if (cen)
         r_step_cnt <= w_step_tick ? '0 : r_step_cnt + 1'b1;
   end

   jt6805_quad_axis #(.ACCW(ACCW)) u_axis_x (
      .clk         (clk),
      .rst         (rst),
      .i_step_tick (w_step_tick),
      .i_strobe    (strobe),
      .i_delta     (w_dx_s),
      .o_a1        (x1),
      .o_a2        (x2)
   );

   jt6805_quad_axis #(.ACCW(ACCW)) u_axis_y (
      .clk         (clk),
      .rst         (rst),
      .i_step_tick (w_step_tick),
      .i_strobe    (strobe),
      .i_delta     (w_dy_s),
      .o_a1        (y1),
      .o_a2        (y2)
   );

   assign w_rise = (x1 && !r_x1_d) || (y1 && !r_y1_d);

   // A rising edge reloads even while counting, so back-to-back edges
   // stretch the pulse instead of leaving a gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x1_d    <= 1'b0;
         r_y1_d    <= 1'b0;
         r_irq_cnt <= '0;
         r_btn_n   <= 1'b1;
      end else begin
         r_x1_d <= x1;
         r_y1_d <= y1;
         if (w_rise)
            r_irq_cnt <= IRQ_LOAD;
         else if (cen && (r_irq_cnt != '0))
            r_irq_cnt <= r_irq_cnt - 1'b1;
         if (strobe)
            r_btn_n <= ~btn;
      end
   end

   assign btn_n = r_btn_n;
   assign irq   = (r_irq_cnt != '0);

endmodule
